// File: rtl/irq_request_latch.sv
// -----------------------------------------------------------------------------
// irq_request_latch
//
// Purpose:
//   Turns rising edges on WIDTH request lines into sticky pending bits. It then
//   offers the highest-index unmasked pending request to a consumer through a
//   registered valid/id pair with an ack handshake. The raw pending vector is
//   exported unmasked so a downstream priority encoder sees every latched
//   event. Every output is a flop; nothing is driven combinationally from the
//   inputs.
//
// Ports:
//   clk        in   1          single clock, rising edge
//   rst        in   1          synchronous active-high reset, wins over all
//   req_in     in   WIDTH      request lines, a 0->1 between samples is an event
//   mask       in   WIDTH      1 = excluded from selection (still latches)
//   irq_ack    in   1          consumer accepts the offered irq_id
//   pending    out  WIDTH      sticky event bits, unmasked
//   irq_valid  out  1          any unmasked pending bit
//   irq_id     out  ID_W       highest unmasked pending index, 0 when idle
//   overflow   out  1          one-cycle pulse: event hit an already-pending bit
// -----------------------------------------------------------------------------
module irq_request_latch #(
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic [WIDTH-1:0] mask,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] pending,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic             overflow
);

  // The id field must be exactly wide enough to index every request line.
  if (ID_W != $clog2(WIDTH)) begin : g_bad_id_w
    $error("irq_request_latch: ID_W must equal $clog2(WIDTH)");
  end

  // One-hot decode of an index; used to clear the bit being serviced.
  function automatic logic [WIDTH-1:0] onehot_f(input logic [ID_W-1:0] idx);
    logic [WIDTH-1:0] res;
    res = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == ID_W'(i)) begin
        res[i] = 1'b1;
      end else begin
        res[i] = 1'b0;
      end
    end
    return res;
  endfunction

  // Index of the highest set bit, 0 when the vector is empty. Scanning upward
  // lets the highest hit overwrite all lower ones.
  function automatic logic [ID_W-1:0] highest_f(input logic [WIDTH-1:0] vec);
    logic [ID_W-1:0] res;
    res = {ID_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        res = ID_W'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [WIDTH-1:0] req_prev_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] pend_nx_s;
  logic [WIDTH-1:0] act_nx_s;
  logic             valid_nx_s;
  logic [ID_W-1:0]  id_nx_s;
  logic             ovf_nx_s;

  // Edge detect, service clear, sticky update and next-cycle selection.
  always_comb begin
    rise_s = req_in & ~req_prev_r;
    // The clear follows the registered offer, so masking that id on the ack
    // cycle does not cancel the service. Acks while idle are ignored.
    if (irq_ack && irq_valid) begin
      clr_s = onehot_f(irq_id);
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    // OR-ing the rise in last makes a new event survive a same-edge clear.
    pend_nx_s  = (pending & ~clr_s) | rise_s;
    ovf_nx_s   = |(rise_s & pending & ~clr_s);
    act_nx_s   = pend_nx_s & ~mask;
    valid_nx_s = |act_nx_s;
    id_nx_s    = highest_f(act_nx_s);
  end

  // State and output registers; reset discards any same-edge event or ack.
  // req_prev resets high so lines already asserted at reset release are not
  // mistaken for fresh events.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_prev_r <= {WIDTH{1'b1}};
      pending    <= {WIDTH{1'b0}};
      irq_valid  <= 1'b0;
      irq_id     <= {ID_W{1'b0}};
      overflow   <= 1'b0;
    end else begin
      req_prev_r <= req_in;
      pending    <= pend_nx_s;
      irq_valid  <= valid_nx_s;
      irq_id     <= id_nx_s;
      overflow   <= ovf_nx_s;
    end
  end

endmodule

// File: doc/irq_request_latch.md
# irq_request_latch

Captures rising edges on four request lines into a sticky pending register and selects the highest-index unmasked pending request for service through a valid/ack handshake. It sits directly upstream of the 4-to-2 priority encoder. Its `pending` vector feeds that encoder's `in` port. It also produces its own registered `irq_valid`/`irq_id` pair for the servicing logic. With `mask` = 0, `irq_id` equals the encoder's combinational output for the same `pending` value.

## Interface
- `WIDTH`, 4, number of request lines; bit `WIDTH-1` has the highest priority.
- `ID_W`, 2, width of `irq_id`; must equal `$clog2(WIDTH)`.
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst`, input, 1, synchronous, active-high reset.
- `req_in`, input, WIDTH, request lines, synchronous to `clk`; a 0→1 transition between consecutive samples is an event.
- `mask`, input, WIDTH, 1 = line excluded from selection; it still latches into `pending`.
- `irq_ack`, input, 1, consumer accepts the current `irq_id`.
- `pending`, output, WIDTH, registered sticky event bits, unmasked; goes to the priority encoder.
- `irq_valid`, output, 1, registered; 1 when any bit of `pending & ~mask` is set.
- `irq_id`, output, ID_W, registered index of the highest set bit of `pending & ~mask`; 0 when `irq_valid` = 0.
- `overflow`, output, 1, registered single-cycle pulse when an event hits a bit that is already pending.

## Operation
- Edge detect:
  - `req_prev` holds the previous sample of `req_in`.
  - `rise = req_in & ~req_prev`.
  - `req_prev` resets to all ones, so lines already high when reset is released produce no event.
- Clear: `clr = onehot(irq_id)` when `irq_ack && irq_valid`, otherwise 0. `irq_ack` while `irq_valid` = 0 is ignored.
- Next pending: `pend_nx = (pending & ~clr) | rise`.
  - Set wins over clear. If an event and an ack hit the same bit on the same edge, the bit stays pending as a new event.
- Overflow: `overflow <= |(rise & pending & ~clr)`.
  - Multiple lines overflowing on one edge produce a single pulse.
  - The lost event is not counted.
- Selection, computed from next-state values:
  - `act_nx = pend_nx & ~mask`.
  - `irq_valid <= |act_nx`.
  - `irq_id <=` highest index set in `act_nx`, else 0.
- No state machine; the block is a pure register stage. Outputs are never driven combinationally from inputs.
- Reset values:
  - `pending` = 0
  - `irq_valid` = 0
  - `irq_id` = 0
  - `overflow` = 0
  - `req_prev` = all ones
- Reset has priority over all other activity. An event or ack on the same edge as `rst` is discarded.

## Timing
- Event latency: `req_in` is first sampled high at edge k (low at edge k-1). After edge k:
  - the `pending` bit is set;
  - `irq_valid`/`irq_id` reflect it;
  - this holds for the cycle following edge k.
- Ack latency: `irq_ack` sampled high at edge k with `irq_valid` high. After edge k:
  - the serviced bit is cleared;
  - `irq_valid`/`irq_id` show the next request, or 0 if none;
  - back-to-back acks on consecutive edges service one request per cycle.
- `mask` sampled at edge k affects `irq_valid`/`irq_id` after edge k; `pending` is unaffected.
- Masking the currently offered `irq_id` in the same cycle as `irq_ack`: the clear still applies. `clr` uses the registered `irq_id`.
- A level held high produces exactly one event. A new event requires `req_in` to go low for at least one sampled cycle.
- `overflow` is high for exactly one cycle, the cycle after the colliding edge.

## Test plan
- Reset release with `req_in` = 4'b0101 held: after 3 edges, `pending` = 0000 and `irq_valid` = 0. Drop `req_in` to 0, then raise bit 0 → `pending` = 0001, `irq_valid` = 1, `irq_id` = 00, one cycle after the edge that sampled it high.
- Events on bits 1 and 3 in the same cycle → `pending` = 1010, `irq_id` = 11. Ack → `pending` = 0010, `irq_id` = 01. Ack → `pending` = 0000, `irq_valid` = 0. Ack with `irq_valid` = 0 → no change.
- `mask` = 1000 while `pending` = 1100 → `irq_id` = 10 one cycle later. Clear `mask` → `irq_id` = 11. `pending` stays 1100 throughout.
- Bit 2 pending. Pulse `req_in[2]` low then high again (second rise) without ack → `overflow` = 1 for one cycle, `pending` unchanged at 0100.
- Ack of `irq_id` = 11 on the same edge as a new rise on bit 3 → `pending[3]` remains 1, `irq_valid` = 1, `overflow` = 0.
- `pending` = 1111, assert `rst` for one cycle with `irq_ack` high → all outputs 0 the following cycle. Compare `pending` through the priority encoder against `irq_id` with `mask` = 0 for every value reached in the run.
